// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline: issues data-memory requests, collects
// multiplier/divider responses and registers the selected writeback value for WB.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] pc,
    input  logic [7:0]  mem_op,
    input  logic [2:0]  mul_op,
    input  logic [3:0]  div_op,
    input  logic        res_from_mul,
    input  logic        res_from_div,
    input  logic        res_from_mem,
    input  logic        mem_we,
    input  logic        gr_we,
    input  logic [4:0]  dest,
    input  logic [31:0] alu_result,
    input  logic [31:0] rkd_value,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        mul_resp_valid,
    output logic        mul_resp_ready,
    input  logic [63:0] mul_result,
    input  logic        div_resp_valid,
    output logic        div_resp_ready,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] pc_out,
    output logic        gr_we_out,
    output logic [4:0]  dest_out,
    output logic [31:0] final_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    mem_state_t  state;
    logic [31:0] rbuf;
    logic        mul_got;
    logic        div_got;
    logic [31:0] mul_buf;
    logic [31:0] div_buf;

    logic        is_mem;
    logic        mem_done;
    logic        mul_hs;
    logic        div_hs;
    logic        mul_ok;
    logic        div_ok;
    logic        ready_go;
    logic        fire;
    logic [1:0]  off;
    logic [31:0] mem_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] mul_sel;
    logic [31:0] div_sel;
    logic [31:0] mul_val;
    logic [31:0] div_val;
    logic [31:0] final_c;
    logic        unused_ok;

    assign unused_ok = ^{mem_op[2], mul_op[2:1], div_op[3], div_op[1]};

    // Handshake and stall control
    assign is_mem   = res_from_mem | mem_we;
    assign mem_done = (state == S_DONE) | ((state == S_WAIT) & data_data_ok);
    assign mul_resp_ready = in_valid & res_from_mul & ~mul_got;
    assign div_resp_ready = in_valid & res_from_div & ~div_got;
    assign mul_hs   = mul_resp_valid & mul_resp_ready;
    assign div_hs   = div_resp_valid & div_resp_ready;
    // A response arriving this cycle counts as already collected (bypass)
    assign mul_ok   = mul_got | mul_hs | ~res_from_mul;
    assign div_ok   = div_got | div_hs | ~res_from_div;
    assign ready_go = ~in_valid | ((mem_done | ~is_mem) & mul_ok & div_ok);
    assign in_ready = ~rst & (~in_valid | (ready_go & out_ready));
    assign fire     = in_valid & ready_go & out_ready;

    // Memory request fields
    assign off        = alu_result[1:0];
    assign data_req   = (state == S_IDLE) & in_valid & is_mem;
    assign data_wr    = mem_we;
    assign data_addr  = alu_result;

    always_comb begin
        data_size  = 2'd2;
        data_wstrb = 4'h0;
        data_wdata = rkd_value;
        if (mem_op[0] | mem_op[3] | mem_op[5]) begin
            data_size = 2'd0;
        end else if (mem_op[1] | mem_op[4] | mem_op[6]) begin
            data_size = 2'd1;
        end
        if (mem_op[5]) begin
            data_wstrb = 4'b0001 << off;
            data_wdata = {4{rkd_value[7:0]}};
        end else if (mem_op[6]) begin
            data_wstrb = 4'b0011 << {off[1], 1'b0};
            data_wdata = {2{rkd_value[15:0]}};
        end else if (mem_op[7]) begin
            data_wstrb = 4'hf;
        end
    end

    // Load extraction; rdata bypasses rbuf in the data_ok cycle
    assign mem_rdata = (state == S_WAIT) ? data_rdata : rbuf;
    assign ld_byte   = 8'(mem_rdata >> {off, 3'b000});
    assign ld_half   = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_val = mem_rdata;
        if (mem_op[0]) begin
            load_val = {{24{ld_byte[7]}}, ld_byte};
        end else if (mem_op[3]) begin
            load_val = {24'h0, ld_byte};
        end else if (mem_op[1]) begin
            load_val = {{16{ld_half[15]}}, ld_half};
        end else if (mem_op[4]) begin
            load_val = {16'h0, ld_half};
        end
    end

    assign mul_sel = mul_op[0] ? mul_result[31:0] : mul_result[63:32];
    assign div_sel = (div_op[0] | div_op[2]) ? div_q : div_r;
    assign mul_val = mul_got ? mul_buf : mul_sel;
    assign div_val = div_got ? div_buf : div_sel;

    assign final_c = res_from_mem ? load_val :
                     res_from_mul ? mul_val  :
                     res_from_div ? div_val  : alu_result;

    // Memory FSM, response buffers and WB-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rbuf      <= 32'h0;
            mul_got   <= 1'b0;
            div_got   <= 1'b0;
            mul_buf   <= 32'h0;
            div_buf   <= 32'h0;
            out_valid <= 1'b0;
            pc_out    <= RESET_PC;
            gr_we_out <= 1'b0;
            dest_out  <= 5'h0;
            final_out <= 32'h0;
        end else begin
            case (state)
                S_IDLE: if (data_req && data_addr_ok) state <= S_WAIT;
                S_WAIT: if (data_data_ok) begin
                    rbuf  <= data_rdata;
                    state <= fire ? S_IDLE : S_DONE;
                end
                S_DONE: if (fire) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (mul_hs) mul_buf <= mul_sel;
            if (div_hs) div_buf <= div_sel;
            if (fire) begin
                mul_got <= 1'b0;
                div_got <= 1'b0;
            end else begin
                if (mul_hs) mul_got <= 1'b1;
                if (div_hs) div_got <= 1'b1;
            end

            if (out_ready) out_valid <= in_valid & ready_go;
            if (fire) begin
                pc_out    <= pc;
                gr_we_out <= gr_we;
                dest_out  <= dest;
                final_out <= final_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// streams against an instruction-level reference model.
module tb_mem_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc;
    logic [7:0]  mem_op;
    logic [2:0]  mul_op;
    logic [3:0]  div_op;
    logic        res_from_mul, res_from_div, res_from_mem, mem_we, gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, rkd_value;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mul_resp_valid, mul_resp_ready;
    logic [63:0] mul_result;
    logic        div_resp_valid, div_resp_ready;
    logic [31:0] div_q, div_r;
    logic [31:0] pc_out;
    logic        gr_we_out;
    logic [4:0]  dest_out;
    logic [31:0] final_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_ov;
    logic [31:0] exp_pc;
    logic        exp_gr;
    logic [4:0]  exp_dest;
    logic [31:0] exp_final;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .mem_op(mem_op),
        .mul_op(mul_op), .div_op(div_op), .res_from_mul(res_from_mul),
        .res_from_div(res_from_div), .res_from_mem(res_from_mem), .mem_we(mem_we),
        .gr_we(gr_we), .dest(dest), .alu_result(alu_result), .rkd_value(rkd_value),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready),
        .mul_result(mul_result), .div_resp_valid(div_resp_valid),
        .div_resp_ready(div_resp_ready), .div_q(div_q), .div_r(div_r),
        .pc_out(pc_out), .gr_we_out(gr_we_out), .dest_out(dest_out), .final_out(final_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  mem_op;
        logic [2:0]  mul_op;
        logic [3:0]  div_op;
        logic        rf_mul, rf_div, rf_mem, we_mem, gr_we;
        logic [4:0]  dest;
        logic [31:0] alu, rkd;
    } instr_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // kind: 0 alu, 1-5 ld.b/h/w/bu/hu, 6-8 st.b/h/w, 9-11 mul, 12-15 div
    function automatic instr_t make_instr(input int kind, input logic [31:0] ipc,
                                          input logic [31:0] alu, input logic [31:0] rkd,
                                          input logic [4:0] rd);
        instr_t t;
        t.pc = ipc; t.alu = alu; t.rkd = rkd; t.dest = rd;
        t.mem_op = 8'h0; t.mul_op = 3'h0; t.div_op = 4'h0;
        t.rf_mul = 1'b0; t.rf_div = 1'b0; t.rf_mem = 1'b0; t.we_mem = 1'b0;
        if (kind >= 1 && kind <= 5) begin
            t.mem_op = 8'(1 << (kind - 1)); t.rf_mem = 1'b1;
        end else if (kind >= 6 && kind <= 8) begin
            t.mem_op = 8'(1 << (kind - 1)); t.we_mem = 1'b1;
        end else if (kind >= 9 && kind <= 11) begin
            t.mul_op = 3'(1 << (kind - 9)); t.rf_mul = 1'b1;
        end else if (kind >= 12) begin
            t.div_op = 4'(1 << (kind - 12)); t.rf_div = 1'b1;
        end
        t.gr_we = ~t.we_mem;
        return t;
    endfunction

    function automatic logic [31:0] model_result(input instr_t t, input logic [31:0] rd,
                                                 input logic [63:0] prod,
                                                 input logic [31:0] q, input logic [31:0] r);
        logic [31:0] b, h;
        b = (rd >> (8 * t.alu[1:0])) & 32'hff;
        h = (rd >> (16 * t.alu[1])) & 32'hffff;
        if (t.rf_mem) begin
            if (t.mem_op[0]) return (b >= 128) ? b + 32'hffffff00 : b;
            if (t.mem_op[3]) return b;
            if (t.mem_op[1]) return (h >= 32768) ? h + 32'hffff0000 : h;
            if (t.mem_op[4]) return h;
            return rd;
        end
        if (t.rf_mul) return t.mul_op[0] ? prod[31:0] : prod[63:32];
        if (t.rf_div) return (t.div_op[0] || t.div_op[2]) ? q : r;
        return t.alu;
    endfunction

    function automatic logic [38:0] model_req(input instr_t t);
        logic [1:0]  sz;
        logic [3:0]  strb;
        logic [31:0] wd;
        sz = 2'd2; strb = 4'h0; wd = t.rkd;
        if (t.mem_op[0] || t.mem_op[3] || t.mem_op[5]) sz = 2'd0;
        if (t.mem_op[1] || t.mem_op[4] || t.mem_op[6]) sz = 2'd1;
        if (t.mem_op[5]) begin
            strb = 4'(1 << t.alu[1:0]); wd = (t.rkd & 32'hff) * 32'h01010101;
        end else if (t.mem_op[6]) begin
            strb = t.alu[1] ? 4'hc : 4'h3; wd = (t.rkd & 32'hffff) * 32'h00010001;
        end else if (t.mem_op[7]) begin
            strb = 4'hf;
        end
        if (!t.we_mem) wd = 32'h0;
        return {t.we_mem, sz, strb, wd};
    endfunction

    task automatic drive_instr(input instr_t t);
        pc = t.pc; mem_op = t.mem_op; mul_op = t.mul_op; div_op = t.div_op;
        res_from_mul = t.rf_mul; res_from_div = t.rf_div; res_from_mem = t.rf_mem;
        mem_we = t.we_mem; gr_we = t.gr_we; dest = t.dest;
        alu_result = t.alu; rkd_value = t.rkd;
    endtask

    task automatic clear_side();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom();
        mul_resp_valid = 1'b0; mul_result = {$urandom(), $urandom()};
        div_resp_valid = 1'b0; div_q = $urandom(); div_r = $urandom();
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        check({tag, ".pc_out"}, 64'(pc_out), 64'(exp_pc));
        check({tag, ".final_out"}, 64'(final_out), 64'(exp_final));
        check({tag, ".dest_gr"}, 64'({dest_out, gr_we_out}), 64'({exp_dest, exp_gr}));
    endtask

    task automatic set_reset_exp();
        exp_ov = 1'b0; exp_pc = RESET_PC; exp_gr = 1'b0; exp_dest = 5'h0; exp_final = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_instr(make_instr(0, 32'h0, 32'h0, 32'h0, 5'h0));
            in_valid = 1'b0;
            out_ready = 1'($urandom_range(1));
            clear_side();
            #1;
            check_outs("idle");
            check("idle.in_ready", 64'(in_ready), 64'd1);
            check("idle.reqs", 64'({data_req, mul_resp_ready, div_resp_ready}), 64'd0);
            @(posedge clk);
            if (out_ready) exp_ov = 1'b0;
        end
    endtask

    // Drive one instruction until it fires, acting as memory and mul/div responders
    task automatic run_instr(input instr_t t, input int addr_lat, input int data_lat,
                             input int unit_lat, input int ready_after, input int ready_pct,
                             input logic [31:0] rd, input logic [63:0] prod,
                             input logic [31:0] q, input logic [31:0] r);
        int cyc = 0, hs_cyc = 0, req_cnt = 0;
        bit addr_done = 0, data_done = 0, unit_done = 0, fired = 0;
        bit is_mem, mem_ok, mul_ok, div_ok, exp_rdy;
        logic [31:0] res;
        is_mem = t.rf_mem | t.we_mem;
        res = model_result(t, rd, prod, q, r);
        while (!fired && cyc < 60) begin
            @(negedge clk);
            drive_instr(t);
            in_valid = 1'b1;
            out_ready = (cyc >= ready_after) && ($urandom_range(99) < ready_pct);
            clear_side();
            data_addr_ok = !addr_done && cyc >= addr_lat;
            data_data_ok = addr_done && !data_done && cyc >= hs_cyc + data_lat;
            if (data_data_ok) data_rdata = rd;
            mul_resp_valid = t.rf_mul && !unit_done && cyc >= unit_lat;
            div_resp_valid = t.rf_div && !unit_done && cyc >= unit_lat;
            if (mul_resp_valid) mul_result = prod;
            if (div_resp_valid) begin div_q = q; div_r = r; end
            #1;
            check_outs("run");
            check("run.mul_ready", 64'(mul_resp_ready), 64'(t.rf_mul && !unit_done));
            check("run.div_ready", 64'(div_resp_ready), 64'(t.rf_div && !unit_done));
            check("run.data_req", 64'(data_req), 64'(is_mem && !addr_done));
            if (is_mem && !addr_done) begin
                check("run.req_addr", 64'(data_addr), 64'(t.alu));
                check("run.req_fields",
                      64'({data_wr, data_size, data_wstrb, t.we_mem ? data_wdata : 32'h0}),
                      64'(model_req(t)));
            end
            mem_ok = !is_mem || data_done || data_data_ok;
            mul_ok = !t.rf_mul || unit_done || mul_resp_valid;
            div_ok = !t.rf_div || unit_done || div_resp_valid;
            exp_rdy = out_ready && mem_ok && mul_ok && div_ok;
            check("run.in_ready", 64'(in_ready), 64'(exp_rdy));
            if (data_addr_ok && is_mem && !addr_done) begin
                addr_done = 1; hs_cyc = cyc + 1; req_cnt++;
            end
            if (data_data_ok) data_done = 1;
            if (mul_resp_valid || div_resp_valid) unit_done = 1;
            fired = exp_rdy;
            @(posedge clk);
            if (out_ready) exp_ov = fired;
            if (fired) begin
                exp_pc = t.pc; exp_gr = t.gr_we; exp_dest = t.dest; exp_final = res;
            end
            cyc++;
        end
        if (!fired) check("run.timeout", 64'd0, 64'd1);
        check("run.req_count", 64'(req_cnt), 64'(is_mem));
        #1;
    endtask

    initial begin
        instr_t t;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        drive_instr(make_instr(0, 32'h0, 32'h0, 32'h0, 5'h0));
        clear_side();
        set_reset_exp();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        check("reset.in_ready", 64'(in_ready), 64'd0);
        check("reset.data_req", 64'(data_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // ld.w with delayed addr_ok
        run_instr(make_instr(3, 32'h1c000100, 32'h100, 32'h0, 5'd4), 2, 1, 0, 0, 100,
                  32'h89abcdef, 64'h0, 32'h0, 32'h0);
        check("ldw.value", 64'(final_out), 64'h89abcdef);
        run_instr(make_instr(1, 32'h1c000104, 32'h101, 32'h0, 5'd5), 0, 1, 0, 0, 100,
                  32'h00008000, 64'h0, 32'h0, 32'h0);
        check("ldb.value", 64'(final_out), 64'hffffff80);
        run_instr(make_instr(4, 32'h1c000108, 32'h101, 32'h0, 5'd6), 1, 2, 0, 0, 100,
                  32'h00008000, 64'h0, 32'h0, 32'h0);
        check("ldbu.value", 64'(final_out), 64'h00000080);
        run_instr(make_instr(5, 32'h1c00010c, 32'h102, 32'h0, 5'd7), 0, 1, 0, 0, 100,
                  32'hbeef0000, 64'h0, 32'h0, 32'h0);
        check("ldhu.value", 64'(final_out), 64'h0000beef);

        // st.b to the top byte lane; request fields checked inside run_instr
        t = make_instr(6, 32'h1c000110, 32'h103, 32'h12345678, 5'd0);
        check("stb.model_fields", 64'(model_req(t)), 64'({1'b1, 2'd0, 4'b1000, 32'h78787878}));
        run_instr(t, 0, 1, 0, 0, 100, 32'h0, 64'h0, 32'h0, 32'h0);
        check("stb.gr_we", 64'(gr_we_out), 64'd0);

        // mulh.wu arriving after three cycles
        run_instr(make_instr(11, 32'h1c000114, 32'h0, 32'h0, 5'd8), 0, 1, 3, 0, 100,
                  32'h0, 64'h00000001_00000002, 32'h0, 32'h0);
        check("mulhwu.value", 64'(final_out), 64'h00000001);

        // WB stalls across data_ok: value must come from the held buffer
        run_instr(make_instr(3, 32'h1c000118, 32'h204, 32'h0, 5'd9), 0, 1, 0, 6, 100,
                  32'hcafef00d, 64'h0, 32'h0, 32'h0);
        check("stall.value", 64'(final_out), 64'hcafef00d);
        idle(2);

        // Reset while waiting for data_ok drops the transaction
        t = make_instr(3, 32'h1c000120, 32'h300, 32'h0, 5'd3);
        @(negedge clk);
        drive_instr(t); in_valid = 1'b1; out_ready = 1'b1; clear_side(); data_addr_ok = 1'b1;
        #1;
        check("rstwait.req", 64'(data_req), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; clear_side();
        @(posedge clk);
        set_reset_exp();
        #1;
        check_outs("rstwait");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwait.data_req", 64'(data_req), 64'd0);
        check_outs("rstwait.after");
        run_instr(make_instr(2, 32'h1c000124, 32'h302, 32'h0, 5'd10), 1, 1, 0, 0, 100,
                  32'h7fff0000, 64'h0, 32'h0, 32'h0);
        check("rstwait.ldh", 64'(final_out), 64'h00007fff);

        // Randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            t = make_instr(int'($urandom_range(15)), $urandom(), $urandom(), $urandom(),
                           5'($urandom_range(31)));
            run_instr(t, int'($urandom_range(3)), int'($urandom_range(1, 3)),
                      int'($urandom_range(3)), int'($urandom_range(2)), 70,
                      $urandom(), {$urandom(), $urandom()}, $urandom(), $urandom());
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
